// File: rtl/tomasula_types.sv
// Shared dispatch/CDB/ALU types for the Tomasulo core.
package tomasula_types;

  typedef enum logic [1:0] {
    OpArith,
    OpArithImm,
    OpBranch,
    OpMem
  } alu_op_e;

  typedef struct packed {
    alu_op_e     op;
    logic [7:0]  src1_reg;
    logic        src1_valid;
    logic [7:0]  src2_reg;
    logic        src2_valid;
    logic [2:0]  funct3;
    logic        funct7;
    logic [7:0]  rd;
    logic [31:0] imm;
  } control_word_t;

  typedef struct packed {
    logic [2:0]  tag;
    logic [31:0] data;
  } cdb_t;

  typedef struct packed {
    alu_op_e     op;
    logic [2:0]  funct3;
    logic        funct7;
    logic [7:0]  rd;
    logic [31:0] imm;
    logic [31:0] opa;
    logic [31:0] opb;
  } alu_data_t;

endpackage

// File: rtl/alu_reservation_station.sv
// ALU reservation station: holds dispatched ops until both operands arrive (directly or
// via CDB snoop), then issues the lowest-index ready entry to the ALU with a start pulse.
module alu_reservation_station
  import tomasula_types::*;
#(
  parameter int unsigned N_ENTRIES = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          load_word_i,
  input  control_word_t control_word_i,
  input  logic [31:0]   src1_i,
  input  logic [31:0]   src2_i,
  input  logic          rob_v1_i,
  input  logic          rob_v2_i,
  input  logic [2:0]    rob_tag1_i,
  input  logic [2:0]    rob_tag2_i,
  input  cdb_t          cdb_i,
  input  logic          alu_free_i,
  output alu_data_t     alu_data_o,
  output logic          start_exe_o,
  output logic          res_empty_o
);

  localparam int unsigned IdxW = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1;
  typedef logic [IdxW-1:0] idx_t;

  typedef struct packed {
    alu_op_e     op;
    logic [2:0]  funct3;
    logic        funct7;
    logic [7:0]  rd;
    logic [31:0] imm;
  } payload_t;

  logic [N_ENTRIES-1:0] busy_q, busy_d, wait1_q, wait1_d, wait2_q, wait2_d;
  payload_t    pay_q  [N_ENTRIES];
  payload_t    pay_d  [N_ENTRIES];
  logic [31:0] val1_q [N_ENTRIES];
  logic [31:0] val1_d [N_ENTRIES];
  logic [31:0] val2_q [N_ENTRIES];
  logic [31:0] val2_d [N_ENTRIES];
  logic [2:0]  tag1_q [N_ENTRIES];
  logic [2:0]  tag1_d [N_ENTRIES];
  logic [2:0]  tag2_q [N_ENTRIES];
  logic [2:0]  tag2_d [N_ENTRIES];

  alu_data_t alu_data_q, alu_data_d;
  logic      start_q, start_d;

  logic [N_ENTRIES-1:0] ready;
  idx_t issue_idx, load_idx;
  logic issue_en, load_en, cdb_valid, byp1, byp2;

  // Source register ids only travel with the op; readiness comes from the wait bits.
  logic unused_src_info;
  assign unused_src_info = ^{control_word_i.src1_reg, control_word_i.src1_valid,
                             control_word_i.src2_reg, control_word_i.src2_valid};

  assign res_empty_o = ~&busy_q;
  assign cdb_valid   = (cdb_i.tag != 3'd0);
  assign byp1        = rob_v1_i && cdb_valid && (cdb_i.tag == rob_tag1_i);
  assign byp2        = rob_v2_i && cdb_valid && (cdb_i.tag == rob_tag2_i);

  // Lowest-index priority pick for both issue and allocation.
  always_comb begin
    ready     = busy_q & ~wait1_q & ~wait2_q;
    issue_idx = '0;
    load_idx  = '0;
    for (int i = N_ENTRIES - 1; i >= 0; i--) begin
      if (ready[i])   issue_idx = idx_t'(i);
      if (!busy_q[i]) load_idx  = idx_t'(i);
    end
    issue_en = alu_free_i && (|ready);
    load_en  = load_word_i && res_empty_o;
  end

  always_comb begin
    busy_d     = busy_q;
    wait1_d    = wait1_q;
    wait2_d    = wait2_q;
    pay_d      = pay_q;
    val1_d     = val1_q;
    val2_d     = val2_q;
    tag1_d     = tag1_q;
    tag2_d     = tag2_q;
    alu_data_d = alu_data_q;
    start_d    = issue_en;

    for (int i = 0; i < N_ENTRIES; i++) begin
      if (busy_q[i] && cdb_valid) begin
        if (wait1_q[i] && (tag1_q[i] == cdb_i.tag)) begin
          val1_d[i]  = cdb_i.data;
          wait1_d[i] = 1'b0;
        end
        if (wait2_q[i] && (tag2_q[i] == cdb_i.tag)) begin
          val2_d[i]  = cdb_i.data;
          wait2_d[i] = 1'b0;
        end
      end
    end

    if (issue_en) begin
      busy_d[issue_idx]   = 1'b0;
      alu_data_d.op       = pay_q[issue_idx].op;
      alu_data_d.funct3   = pay_q[issue_idx].funct3;
      alu_data_d.funct7   = pay_q[issue_idx].funct7;
      alu_data_d.rd       = pay_q[issue_idx].rd;
      alu_data_d.imm      = pay_q[issue_idx].imm;
      alu_data_d.opa      = val1_q[issue_idx];
      alu_data_d.opb      = val2_q[issue_idx];
    end

    // load_idx is never the issuing slot: a ready slot is busy, so it is not picked.
    if (load_en) begin
      busy_d[load_idx]        = 1'b1;
      pay_d[load_idx].op      = control_word_i.op;
      pay_d[load_idx].funct3  = control_word_i.funct3;
      pay_d[load_idx].funct7  = control_word_i.funct7;
      pay_d[load_idx].rd      = control_word_i.rd;
      pay_d[load_idx].imm     = control_word_i.imm;
      tag1_d[load_idx]        = rob_tag1_i;
      tag2_d[load_idx]        = rob_tag2_i;
      wait1_d[load_idx]       = rob_v1_i && !byp1;
      wait2_d[load_idx]       = rob_v2_i && !byp2;
      val1_d[load_idx]        = byp1 ? cdb_i.data : src1_i;
      val2_d[load_idx]        = byp2 ? cdb_i.data : src2_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_q     <= '0;
      wait1_q    <= '0;
      wait2_q    <= '0;
      alu_data_q <= '0;
      start_q    <= 1'b0;
      for (int i = 0; i < N_ENTRIES; i++) begin
        pay_q[i]  <= '0;
        val1_q[i] <= '0;
        val2_q[i] <= '0;
        tag1_q[i] <= '0;
        tag2_q[i] <= '0;
      end
    end else begin
      busy_q     <= busy_d;
      wait1_q    <= wait1_d;
      wait2_q    <= wait2_d;
      alu_data_q <= alu_data_d;
      start_q    <= start_d;
      pay_q      <= pay_d;
      val1_q     <= val1_d;
      val2_q     <= val2_d;
      tag1_q     <= tag1_d;
      tag2_q     <= tag2_d;
    end
  end

  assign alu_data_o  = alu_data_q;
  assign start_exe_o = start_q;

endmodule

// File: tb/tb_alu_reservation_station.sv
// Directed bench for alu_reservation_station with an in-bench station model.
module tb_alu_reservation_station;
  import tomasula_types::*;

  localparam int unsigned N = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load_word;
  control_word_t cw;
  logic [31:0]   src1, src2;
  logic          rob_v1, rob_v2;
  logic [2:0]    rob_tag1, rob_tag2;
  cdb_t          cdb;
  logic          alu_free;
  alu_data_t     alu_data;
  logic          start_exe, res_empty;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_reservation_station #(.N_ENTRIES(N)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .load_word_i    (load_word),
    .control_word_i (cw),
    .src1_i         (src1),
    .src2_i         (src2),
    .rob_v1_i       (rob_v1),
    .rob_v2_i       (rob_v2),
    .rob_tag1_i     (rob_tag1),
    .rob_tag2_i     (rob_tag2),
    .cdb_i          (cdb),
    .alu_free_i     (alu_free),
    .alu_data_o     (alu_data),
    .start_exe_o    (start_exe),
    .res_empty_o    (res_empty)
  );

  // ---------------- model: a list of station slots ----------------
  typedef struct {
    bit            busy;
    bit            w1, w2;
    logic [2:0]    t1, t2;
    logic [31:0]   v1, v2;
    control_word_t cw;
  } slot_t;

  slot_t     m [N];
  bit        exp_start;
  alu_data_t exp_alu;

  function automatic bit model_has_free();
    for (int i = 0; i < N; i++) if (!m[i].busy) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m[i].busy = 0; m[i].w1 = 0; m[i].w2 = 0;
    end
    exp_start = 0;
    exp_alu   = '0;
  endtask

  task automatic model_edge();
    int iss = -1;
    int slot = -1;
    for (int i = 0; i < N; i++) begin
      if (iss < 0 && alu_free && m[i].busy && !m[i].w1 && !m[i].w2) iss = i;
      if (slot < 0 && !m[i].busy) slot = i;
    end
    exp_start = (iss >= 0);
    if (iss >= 0) begin
      exp_alu = '{op: m[iss].cw.op, funct3: m[iss].cw.funct3, funct7: m[iss].cw.funct7,
                  rd: m[iss].cw.rd, imm: m[iss].cw.imm, opa: m[iss].v1, opb: m[iss].v2};
      m[iss].busy = 0;
    end
    if (cdb.tag != 0) begin
      for (int i = 0; i < N; i++) begin
        if (m[i].busy && m[i].w1 && m[i].t1 == cdb.tag) begin m[i].v1 = cdb.data; m[i].w1 = 0; end
        if (m[i].busy && m[i].w2 && m[i].t2 == cdb.tag) begin m[i].v2 = cdb.data; m[i].w2 = 0; end
      end
    end
    if (load_word && slot >= 0) begin
      m[slot].busy = 1;
      m[slot].cw   = cw;
      m[slot].t1   = rob_tag1;
      m[slot].t2   = rob_tag2;
      m[slot].w1   = rob_v1;
      m[slot].w2   = rob_v2;
      m[slot].v1   = src1;
      m[slot].v2   = src2;
      if (rob_v1 && cdb.tag != 0 && cdb.tag == rob_tag1) begin
        m[slot].v1 = cdb.data; m[slot].w1 = 0;
      end
      if (rob_v2 && cdb.tag != 0 && cdb.tag == rob_tag2) begin
        m[slot].v2 = cdb.data; m[slot].w2 = 0;
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else model_edge();
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_alu(input string name, input alu_data_t act, input alu_data_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      chk("model start_exe", 32'(start_exe), 32'(exp_start));
      chk_alu("model alu_data", alu_data, exp_alu);
      chk("model res_empty", 32'(res_empty), 32'(model_has_free()));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_in();
    load_word = 0; cw = '0; src1 = '0; src2 = '0;
    rob_v1 = 0; rob_v2 = 0; rob_tag1 = '0; rob_tag2 = '0; cdb = '0;
  endtask

  task automatic set_load(input logic [31:0] s1, input logic [31:0] s2,
                          input logic v1, input logic [2:0] t1,
                          input logic v2, input logic [2:0] t2, input logic [7:0] rd);
    load_word = 1;
    cw = '0;
    cw.op = OpArith;
    cw.rd = rd;
    cw.funct3 = rd[2:0];
    cw.imm = {24'h0, rd};
    src1 = s1; src2 = s2;
    rob_v1 = v1; rob_tag1 = t1; rob_v2 = v2; rob_tag2 = t2;
  endtask

  initial begin
    clear_in();
    alu_free = 1;
    // Reset held for 5 cycles
    repeat (5) step();
    chk("reset start_exe", 32'(start_exe), 32'h0);
    chk("reset alu_data", 32'(alu_data.opa | alu_data.opb | 32'(alu_data.rd)), 32'h0);
    chk("reset res_empty", 32'(res_empty), 32'h1);
    rst = 0;
    repeat (2) step();
    chk("idle start_exe", 32'(start_exe), 32'h0);

    // Pending operand resolved by CDB
    set_load(32'd5, 32'd3, 1, 3'd1, 0, 3'd0, 8'd3);
    step();
    clear_in();
    chk("pend no issue", 32'(start_exe), 32'h0);
    repeat (2) step();
    chk("pend still waiting", 32'(start_exe), 32'h0);
    cdb = '{tag: 3'd1, data: 32'd2};
    step();
    cdb = '0;
    chk("pend capture edge", 32'(start_exe), 32'h0);
    step();
    chk("pend start", 32'(start_exe), 32'h1);
    chk("pend opa", alu_data.opa, 32'd2);
    chk("pend opb", alu_data.opb, 32'd3);
    chk("pend rd", 32'(alu_data.rd), 32'd3);
    step();
    chk("pend single pulse", 32'(start_exe), 32'h0);

    // Ready load while ALU busy
    alu_free = 0;
    set_load(32'd7, 32'd9, 0, 3'd0, 0, 3'd0, 8'd4);
    step();
    clear_in();
    repeat (2) step();
    chk("alubusy no issue", 32'(start_exe), 32'h0);
    alu_free = 1;
    step();
    chk("alufree start", 32'(start_exe), 32'h1);
    chk("alufree opa", alu_data.opa, 32'd7);
    chk("alufree opb", alu_data.opb, 32'd9);
    step();
    chk("alufree one pulse", 32'(start_exe), 32'h0);
    chk("alufree res_empty", 32'(res_empty), 32'h1);

    // Same-edge CDB bypass at load
    set_load(32'h11, 32'h99, 0, 3'd0, 1, 3'd5, 8'd5);
    cdb = '{tag: 3'd5, data: 32'hAB};
    step();
    clear_in();
    chk("bypass load edge", 32'(start_exe), 32'h0);
    step();
    chk("bypass start", 32'(start_exe), 32'h1);
    chk("bypass opa", alu_data.opa, 32'h11);
    chk("bypass opb", alu_data.opb, 32'hAB);

    // Fill every entry with waiting ops
    for (int i = 0; i < N; i++) begin
      set_load(32'h0, 32'(i), 1, 3'd3, 0, 3'd0, 8'(10 + i));
      step();
    end
    clear_in();
    chk("full res_empty", 32'(res_empty), 32'h0);
    set_load(32'h1, 32'h2, 0, 3'd0, 0, 3'd0, 8'd99);
    step();
    clear_in();
    chk("full extra ignored", 32'(res_empty), 32'h0);
    step();
    chk("full no stray issue", 32'(start_exe), 32'h0);
    cdb = '{tag: 3'd3, data: 32'h30};
    step();
    cdb = '0;
    for (int i = 0; i < N; i++) begin
      step();
      chk("drain start", 32'(start_exe), 32'h1);
      chk("drain order rd", 32'(alu_data.rd), 32'(10 + i));
      chk("drain opa", alu_data.opa, 32'h30);
      chk("drain opb", alu_data.opb, 32'(i));
    end
    chk("drain res_empty", 32'(res_empty), 32'h1);
    step();
    chk("drain done", 32'(start_exe), 32'h0);

    // Load in the same edge as an issue from a full station is dropped
    alu_free = 0;
    set_load(32'h40, 32'h41, 0, 3'd0, 0, 3'd0, 8'd20);
    step();
    for (int i = 1; i < N; i++) begin
      set_load(32'h0, 32'h0, 1, 3'd4, 0, 3'd0, 8'(20 + i));
      step();
    end
    alu_free = 1;
    set_load(32'h5, 32'h6, 0, 3'd0, 0, 3'd0, 8'd77);
    step();
    clear_in();
    chk("samedge issue rd", 32'(alu_data.rd), 32'd20);
    chk("samedge slot freed", 32'(res_empty), 32'h1);
    step();
    chk("samedge load dropped", 32'(start_exe), 32'h0);
    cdb = '{tag: 3'd4, data: 32'h44};
    step();
    cdb = '0;
    repeat (N) step();
    step();

    // Tag-0 broadcast must not be captured
    set_load(32'h1234, 32'h1, 0, 3'd0, 0, 3'd0, 8'd6);
    cdb = '{tag: 3'd0, data: 32'h55};
    step();
    clear_in();
    step();
    chk("tag0 start", 32'(start_exe), 32'h1);
    chk("tag0 opa", alu_data.opa, 32'h1234);

    // Asynchronous reset during a start pulse
    set_load(32'h8, 32'h9, 0, 3'd0, 0, 3'd0, 8'd8);
    step();
    clear_in();
    set_load(32'h0, 32'h0, 1, 3'd2, 0, 3'd0, 8'd9);
    @(posedge clk);
    #2;
    chk("midrst pulse up", 32'(start_exe), 32'h1);
    rst = 1;
    #1;
    chk("midrst start drop", 32'(start_exe), 32'h0);
    chk("midrst alu_data", alu_data.opa, 32'h0);
    chk("midrst res_empty", 32'(res_empty), 32'h1);
    @(negedge clk);
    clear_in();
    step();
    rst = 0;
    cdb = '{tag: 3'd2, data: 32'h22};
    step();
    cdb = '0;
    step();
    chk("postrst entries gone", 32'(start_exe), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
